// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Purpose  : Commit-stage exception/ERET sequencer (FLUSH -> COMMIT -> REDIRECT).
//            Optional timer interrupt source enabled by macro TIMER_INT_EN.
// Revision : 1.0  initial release
// ============================================================================
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  req_i,
    input  logic [5:0]  int_req_i,
    input  logic        ie_i,
    input  logic        exl_i,
    input  logic        eret_i,
    input  logic [31:0] pc_i,
    input  logic        bd_i,
    input  logic [31:0] badva_i,
    input  logic [31:0] epc_i,
    input  logic        cp0_ack_i,
`ifdef TIMER_INT_EN
    input  logic        cmp_we_i,
    input  logic [31:0] cmp_wdata_i,
    input  logic        im7_i,
    output logic        timer_ip_o,
`endif
    output logic        flush_o,
    output logic        stall_o,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_exccode_o,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_bd_o,
    output logic        cp0_badva_we_o,
    output logic [31:0] cp0_badva_o,
    output logic        exl_clr_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state_q;
    logic        eret_q;
    logic        flush_q, stall_q, we_q, bd_q, badva_we_q, badva_pend_q;
    logic        exl_clr_q, redirect_q, busy_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q, badva_q;

    logic [5:0]  int_eff;
    logic        take_d;
    logic [4:0]  code_d;
    logic        badva_cause_d;
    logic [31:0] badva_d;

`ifdef TIMER_INT_EN
    logic        div_q;
    logic [31:0] count_q, compare_q;
    logic        timer_pend_q;

    // A compare write clears the pending flag even if count matches that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= 1'b0;
            count_q      <= '0;
            compare_q    <= '0;
            timer_pend_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
            if (div_q)
                count_q <= count_q + 32'd1;
            if (cmp_we_i) begin
                compare_q    <= cmp_wdata_i;
                timer_pend_q <= 1'b0;
            end else if (count_q == compare_q) begin
                timer_pend_q <= 1'b1;
            end
        end
    end

    assign int_eff    = {int_req_i[5] | (timer_pend_q & im7_i), int_req_i[4:0]};
    assign timer_ip_o = timer_pend_q;
`else
    assign int_eff = int_req_i;
`endif

    assign take_d = ~exl_i & ((|req_i) | (ie_i & (|int_eff)));

    always_comb begin
        code_d        = 5'd0;
        badva_cause_d = 1'b0;
        badva_d       = badva_i;
        if (ie_i && (|int_eff)) begin
            code_d = 5'd0;
        end else if (req_i[0]) begin
            code_d        = 5'd4;
            badva_cause_d = 1'b1;
            badva_d       = pc_i;
        end else if (req_i[1]) begin
            code_d = 5'd10;
        end else if (req_i[2]) begin
            code_d = 5'd12;
        end else if (req_i[3]) begin
            code_d = 5'd8;
        end else if (req_i[4]) begin
            code_d = 5'd9;
        end else if (req_i[5]) begin
            code_d        = 5'd4;
            badva_cause_d = 1'b1;
        end else if (req_i[6]) begin
            code_d        = 5'd5;
            badva_cause_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            eret_q       <= 1'b0;
            flush_q      <= 1'b0;
            stall_q      <= 1'b0;
            we_q         <= 1'b0;
            code_q       <= '0;
            epc_q        <= '0;
            bd_q         <= 1'b0;
            badva_we_q   <= 1'b0;
            badva_pend_q <= 1'b0;
            badva_q      <= '0;
            exl_clr_q    <= 1'b0;
            redirect_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_d) begin
                        state_q      <= FLUSH;
                        eret_q       <= 1'b0;
                        code_q       <= code_d;
                        bd_q         <= bd_i;
                        epc_q        <= bd_i ? (pc_i - 32'd4) : pc_i;
                        badva_pend_q <= badva_cause_d;
                        if (badva_cause_d)
                            badva_q <= badva_d;
                        flush_q      <= 1'b1;
                        stall_q      <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (eret_i) begin
                        state_q <= FLUSH;
                        eret_q  <= 1'b1;
                        flush_q <= 1'b1;
                        stall_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FLUSH: begin
                    flush_q <= 1'b0;
                    if (eret_q) begin
                        state_q    <= REDIRECT;
                        stall_q    <= 1'b0;
                        redirect_q <= 1'b1;
                        exl_clr_q  <= 1'b1;
                    end else begin
                        state_q    <= COMMIT;
                        we_q       <= 1'b1;
                        badva_we_q <= badva_pend_q;
                    end
                end
                COMMIT: begin
                    if (cp0_ack_i) begin
                        state_q    <= REDIRECT;
                        we_q       <= 1'b0;
                        badva_we_q <= 1'b0;
                        stall_q    <= 1'b0;
                        redirect_q <= 1'b1;
                    end
                end
                REDIRECT: begin
                    state_q    <= IDLE;
                    eret_q     <= 1'b0;
                    redirect_q <= 1'b0;
                    exl_clr_q  <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flush_o        = flush_q;
    assign stall_o        = stall_q;
    assign cp0_we_o       = we_q;
    assign cp0_exccode_o  = code_q;
    assign cp0_epc_o      = epc_q;
    assign cp0_bd_o       = bd_q;
    assign cp0_badva_we_o = badva_we_q;
    assign cp0_badva_o    = badva_q;
    assign exl_clr_o      = exl_clr_q;
    assign redirect_o     = redirect_q;
    assign busy_o         = busy_q;
    // ERET target is the live EPC, so it is muxed rather than registered.
    assign redirect_pc_o  = (state_q == REDIRECT && eret_q) ? epc_i : EXC_VECTOR;

endmodule
`default_nettype wire

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have parameter EXC_VECTOR, default 32'hBFC00380, meaning the exception entry address driven on redirect_pc.
REQ-002 The block SHALL have exactly one clock and a synchronous, active-high reset, as follows:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
REQ-003 The block SHALL have the following inputs:
- req  in  7  exception requests from the commit stage: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL-load, [6] AdES
- int_req  in  6  Cause.IP[7:2] AND Status.IM[7:2], already masked
- ie, exl  in  1 each  Status.IE and Status.EXL
- eret  in  1  ERET at the commit stage
- pc_in  in  32  commit-stage instruction PC
- bd_in  in  1  commit-stage instruction is in a delay slot
- badva_in  in  32  faulting data address
- epc_in  in  32  current CP0 EPC
- cp0_ack  in  1  CP0 has accepted the write
REQ-004 The block SHALL have the following outputs:
- flush  out  1  flush IF..MEM
- stall  out  1  freeze the pipeline
- cp0_we  out  1  CP0 exception write strobe
- cp0_exccode  out  5  ExcCode
- cp0_epc  out  32  value for EPC
- cp0_bd  out  1  value for Cause.BD
- cp0_badva_we  out  1  BadVAddr write enable
- cp0_badva  out  32  value for BadVAddr
- exl_clr  out  1  one-cycle pulse that clears EXL
- redirect  out  1  one-cycle PC redirect pulse
- redirect_pc  out  32  redirect target
- busy  out  1  FSM is not in IDLE

Function
REQ-005 The FSM SHALL have states IDLE, FLUSH, COMMIT and REDIRECT.
REQ-006 In IDLE, an exception SHALL be taken when exl=0 and either any req bit is set or (ie=1 and int_req!=0); req and int_req SHALL be ignored while exl=1.
REQ-007 Exception priority SHALL be, highest first:
- interrupt, code 0
- AdEL-fetch, code 4
- RI, code 10
- Ov, code 12
- Sys, code 8
- Bp, code 9
- AdEL-load, code 4
- AdES, code 5
REQ-008 On taking an exception, the block SHALL latch the ExcCode, cp0_bd=bd_in and cp0_epc=(bd_in ? pc_in-4 : pc_in), then go to FLUSH.
REQ-009 cp0_badva SHALL latch pc_in for AdEL-fetch and badva_in for AdEL-load or AdES; cp0_badva_we SHALL accompany cp0_we only for those three causes.
REQ-010 In IDLE, eret=1 with no exception taken SHALL go to FLUSH with the eret flag latched; when an exception and eret occur in the same cycle, the exception SHALL win and eret SHALL be dropped.
REQ-011 FLUSH SHALL last exactly 1 cycle with flush=1, then go to COMMIT, or to REDIRECT when the eret flag is set.
REQ-012 COMMIT SHALL hold cp0_we=1, with all cp0_* outputs stable, until a cycle in which cp0_ack=1, then go to REDIRECT the following cycle; cp0_ack present on the first COMMIT cycle SHALL give a one-cycle COMMIT.
REQ-013 REDIRECT SHALL last 1 cycle with redirect=1 and redirect_pc=EXC_VECTOR for an exception, or redirect_pc=epc_in sampled in that cycle for an eret; an eret SHALL also pulse exl_clr=1; the next state SHALL be IDLE.
REQ-014 stall SHALL be 1 in FLUSH and COMMIT and 0 otherwise; busy SHALL be 1 in every state other than IDLE.
REQ-015 Minimum exception latency, from the request cycle N, SHALL be: flush at N+1, cp0_we at N+2, redirect at N+3.
REQ-016 In non-IDLE states, req, int_req and eret SHALL be ignored; no request is queued.
REQ-017 cp0_ack outside COMMIT SHALL be ignored.

Reset
REQ-018 On rst=1 at a clock edge, the state SHALL become IDLE, the eret flag SHALL be cleared, and every output SHALL be 0 except redirect_pc=EXC_VECTOR.
REQ-019 rst SHALL take priority over every other event, including mid-COMMIT, where cp0_we SHALL drop in the same cycle.

Configuration
REQ-020 With TIMER_INT_EN defined, the block SHALL include a 32-bit count, incremented every second clk, and a 32-bit compare register written via added inputs cmp_we (1 bit) and cmp_wdata (32 bits).
REQ-021 With TIMER_INT_EN defined, count==compare SHALL set a sticky timer_pend; a cmp_we write SHALL clear timer_pend; timer_pend AND added input im7 SHALL OR into int_req[5]; added output timer_ip (1 bit) SHALL drive Cause.IP7; count and compare SHALL reset to 0.
REQ-022 Without TIMER_INT_EN, the count, compare, cmp_we, cmp_wdata, im7 and timer_ip logic and ports SHALL be absent, and int_req SHALL be used unmodified.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- req=7'b0000100 (Ov), pc_in=32'h80001000, bd_in=0, cp0_ack tied 1 -> flush@N+1, cp0_we@N+2 with exccode=12 and epc=32'h80001000, redirect@N+3 to 32'hBFC00380.
- req=7'b0001000 (Sys), bd_in=1, pc_in=32'h80002004 -> cp0_epc=32'h80002000, cp0_bd=1, exccode=8, cp0_badva_we=0.
- req=7'b0100001 with ie=1 and int_req=6'b000001 -> exccode=0 (interrupt wins); then with ie=0 -> exccode=4 and cp0_badva=pc_in.
- eret=1 with req=7'b0000010 in the same cycle -> exccode=10, no exl_clr; eret alone with epc_in=32'h80003000 -> flush, then redirect to 32'h80003000 with exl_clr=1, and cp0_we never asserts.
- cp0_ack held low 5 cycles in COMMIT, with rst asserted on cycle 3 -> cp0_we stays high cycles 1-2, all outputs 0 and busy=0 on the cycle after the rst edge.
- (TIMER_INT_EN) compare=4, im7=1, ie=1 -> timer_pend after 8-9 cycles, an exception with exccode=0 is taken, and a cmp_we write clears timer_ip.
